// File: rtl/count_capture_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : count_capture_pkg
//  Description : Shared defaults, the capture entry type and the occupancy
//                width helper for the count capture FIFO.
//  Revision    : 1.0 - initial release
// ============================================================================
package count_capture_pkg;

  // Defaults match the upstream 4-bit free-running counter.
  localparam int CNT_W_DEF  = 4;
  localparam int WRAP_W_DEF = 8;
  localparam int DEPTH_DEF  = 4;

  // One captured timestamp: counter value plus the extended wrap count.
  typedef struct packed {
    logic [CNT_W_DEF-1:0]  count;
    logic [WRAP_W_DEF-1:0] wraps;
  } cap_entry_t;

  // Occupancy must represent 0..DEPTH inclusive, hence the extra bit.
  function automatic int level_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/capture_fifo_core.sv
`default_nettype none
// ============================================================================
//  Module      : capture_fifo_core
//  Description : Generic synchronous first-word-fall-through FIFO.
//                The head entry is visible on pop_data whenever empty=0;
//                while empty, pop_data holds the last head that was shown.
//  Revision    : 1.0 - initial release
//
//  Ports
//    clk        in   clock, all updates on rising edge
//    reset      in   asynchronous active-low reset
//    flush      in   synchronous empty; overrides push and pop
//    push       in   write request
//    push_data  in   entry to write
//    pop        in   read request (ignored while empty)
//    pop_data   out  head entry / last head when empty
//    empty      out  no entries stored
//    level      out  current occupancy
//    dropped    out  push refused this cycle because full with no pop
// ============================================================================
module capture_fifo_core
  import count_capture_pkg::*;
#(
  parameter int  DEPTH   = DEPTH_DEF,
  parameter type ENTRY_T = cap_entry_t
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          flush,
  input  logic                          push,
  input  ENTRY_T                        push_data,
  input  logic                          pop,
  output ENTRY_T                        pop_data,
  output logic                          empty,
  output logic [level_width(DEPTH)-1:0] level,
  output logic                          dropped
);

  localparam int AW = $clog2(DEPTH);

  ENTRY_T        mem [DEPTH];
  ENTRY_T        head;
  ENTRY_T        hold;
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic          full;
  logic          do_push;
  logic          do_pop;

  // Pointers carry one extra wrap bit so full and empty are distinguishable
  // and the occupancy is a plain subtraction.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                 (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign level = wr_ptr - rd_ptr;

  // A full FIFO still accepts a push when the head leaves in the same cycle.
  // An empty FIFO never bypasses: the pushed entry appears next cycle.
  assign do_pop  = pop && !empty && !flush;
  assign do_push = push && (!full || do_pop) && !flush;
  assign dropped = push && full && !do_pop && !flush;

  assign head     = mem[rd_ptr[AW-1:0]];
  assign pop_data = empty ? hold : head;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      hold   <= '0;
    end else begin
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (do_push) wr_ptr <= wr_ptr + 1'b1;
        if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      end
      // Remember the most recently presented head so the outputs stay put
      // once the FIFO drains.
      if (!empty) hold <= head;
    end
  end

  // Storage needs no reset: nothing is read before it has been written.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule
`default_nettype wire

// File: rtl/count_capture_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : count_capture_fifo
//  Description : Consumer of a free-running up counter. Counts counter
//                wrap-arounds (max -> 0) in an extended wrap counter and, on
//                a capture strobe, queues {count, wraps} into a FWFT FIFO
//                read through a valid/ready interface.
//  Revision    : 1.0 - initial release
//
//  Build option
//    CAPTURE_ON_WRAP_EN  when defined, every wrap also queues an entry;
//                        a capture in the wrap cycle still yields one entry.
//
//  Ports
//    clk        in   clock, all updates on rising edge
//    reset      in   asynchronous active-low reset
//    clear      in   synchronous flush of FIFO, wrap counter and overflow
//    count_in   in   counter value, sampled every cycle
//    capture    in   push request, one entry per asserted cycle
//    out_valid  out  head entry available
//    out_ready  in   reader accepts head when out_valid & out_ready
//    out_count  out  head count field (holds last value when empty)
//    out_wraps  out  head wrap-count field (holds last value when empty)
//    level      out  FIFO occupancy
//    overflow   out  sticky: a push was dropped while full
// ============================================================================
module count_capture_fifo
  import count_capture_pkg::*;
#(
  parameter int CNT_W  = CNT_W_DEF,
  parameter int WRAP_W = WRAP_W_DEF,
  parameter int DEPTH  = DEPTH_DEF
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          clear,
  input  logic [CNT_W-1:0]              count_in,
  input  logic                          capture,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [CNT_W-1:0]              out_count,
  output logic [WRAP_W-1:0]             out_wraps,
  output logic [level_width(DEPTH)-1:0] level,
  output logic                          overflow
);

  // Same layout as cap_entry_t, but sized from this instance's parameters.
  typedef struct packed {
    logic [CNT_W-1:0]  count;
    logic [WRAP_W-1:0] wraps;
  } entry_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0]  prev_cnt;
  logic [WRAP_W-1:0] wraps;
  logic [WRAP_W-1:0] wraps_next;
  logic              wrap;
  logic              push_req;
  logic              fifo_empty;
  logic              dropped;
  entry_t            push_entry;
  entry_t            head_entry;

  assign wrap       = (prev_cnt == CNT_MAX) && (count_in == '0);
  assign wraps_next = wraps + WRAP_W'(wrap);

  // The entry already includes a wrap happening in the capture cycle.
  assign push_entry.count = count_in;
  assign push_entry.wraps = wraps_next;

`ifdef CAPTURE_ON_WRAP_EN
  // OR-ing keeps a coincident capture and wrap down to a single entry.
  assign push_req = capture | wrap;
`else
  assign push_req = capture;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prev_cnt <= '0;
      wraps    <= '0;
      overflow <= 1'b0;
    end else begin
      // The wrap detector keeps tracking the counter even during clear.
      prev_cnt <= count_in;
      if (clear) begin
        wraps    <= '0;
        overflow <= 1'b0;
      end else begin
        wraps <= wraps_next;
        if (dropped) overflow <= 1'b1;
      end
    end
  end

  capture_fifo_core #(
    .DEPTH   (DEPTH),
    .ENTRY_T (entry_t)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .flush     (clear),
    .push      (push_req),
    .push_data (push_entry),
    .pop       (out_ready),
    .pop_data  (head_entry),
    .empty     (fifo_empty),
    .level     (level),
    .dropped   (dropped)
  );

  assign out_valid = !fifo_empty;
  assign out_count = head_entry.count;
  assign out_wraps = head_entry.wraps;

endmodule
`default_nettype wire
